// File: rtl/ex_mem_register.sv
// EX/MEM pipeline register with stall, flush/branch-kill bubbles and registered control/data.
// Optional EX_MEM_ADDR_GUARD_EN flags out-of-range memory addresses and suppresses the store.
module ex_mem_register #(
   parameter int unsigned ADDR_WIDTH = 7,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned REG_BITS   = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  mem_pc_src,
   input  logic                  ex_valid,
   input  logic                  ex_branch,
   input  logic                  ex_mem_write,
   input  logic                  ex_mem_read,
   input  logic                  ex_reg_write,
   input  logic                  ex_mem_to_reg,
   input  logic                  ex_zero,
   input  logic [DATA_WIDTH-1:0] ex_alu_result,
   input  logic [DATA_WIDTH-1:0] ex_write_data,
   input  logic [REG_BITS-1:0]   ex_write_reg,
   input  logic [DATA_WIDTH-1:0] ex_branch_target,
   output logic                  mem_valid,
   output logic                  mem_branch,
   output logic                  mem_mem_write,
   output logic                  mem_mem_read,
   output logic                  mem_reg_write,
   output logic                  mem_mem_to_reg,
   output logic                  mem_zero,
   output logic [DATA_WIDTH-1:0] mem_alu_result,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   output logic [REG_BITS-1:0]   mem_write_reg,
   output logic [DATA_WIDTH-1:0] mem_branch_target,
   output logic                  mem_addr_fault
);

   typedef struct packed {
      logic                  valid;
      logic                  branch;
      logic                  mem_write;
      logic                  mem_read;
      logic                  reg_write;
      logic                  mem_to_reg;
      logic                  zero;
      logic [DATA_WIDTH-1:0] alu_result;
      logic [DATA_WIDTH-1:0] write_data;
      logic [REG_BITS-1:0]   write_reg;
      logic [DATA_WIDTH-1:0] branch_target;
   } stage_t;

   stage_t stage_q, stage_d;
   logic   bubble;
   logic   addr_fault_d;

   assign bubble = flush | mem_pc_src;

`ifdef EX_MEM_ADDR_GUARD_EN
   logic addr_fault_q;
   assign addr_fault_d = ex_valid & (ex_mem_write | ex_mem_read)
                         & (|ex_alu_result[DATA_WIDTH-1:ADDR_WIDTH]);
`else
   assign addr_fault_d = 1'b0;
`endif

   // An invalid EX slot is loaded as a full bubble, so control never outlives valid.
   always_comb begin
      stage_d = '0;
      if (bubble) begin
         stage_d = '0;
      end else if (stall) begin
         stage_d = stage_q;
      end else if (ex_valid) begin
         stage_d.valid         = 1'b1;
         stage_d.branch        = ex_branch;
         stage_d.mem_write     = ex_mem_write & ~addr_fault_d;
         stage_d.mem_read      = ex_mem_read;
         stage_d.reg_write     = ex_reg_write;
         stage_d.mem_to_reg    = ex_mem_to_reg;
         stage_d.zero          = ex_zero;
         stage_d.alu_result    = ex_alu_result;
         stage_d.write_data    = ex_write_data;
         stage_d.write_reg     = ex_write_reg;
         stage_d.branch_target = ex_branch_target;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

`ifdef EX_MEM_ADDR_GUARD_EN
   always_ff @(posedge clk) begin
      if (reset || bubble) begin
         addr_fault_q <= 1'b0;
      end else if (!stall) begin
         addr_fault_q <= addr_fault_d;
      end
   end
   assign mem_addr_fault = addr_fault_q;
`else
   assign mem_addr_fault = 1'b0;
`endif

   assign mem_valid         = stage_q.valid;
   assign mem_branch        = stage_q.branch;
   assign mem_mem_write     = stage_q.mem_write;
   assign mem_mem_read      = stage_q.mem_read;
   assign mem_reg_write     = stage_q.reg_write;
   assign mem_mem_to_reg    = stage_q.mem_to_reg;
   assign mem_zero          = stage_q.zero;
   assign mem_alu_result    = stage_q.alu_result;
   assign mem_address       = stage_q.alu_result[ADDR_WIDTH-1:0];
   assign mem_write_data    = stage_q.write_data;
   assign mem_write_reg     = stage_q.write_reg;
   assign mem_branch_target = stage_q.branch_target;

endmodule

// File: tb/tb_ex_mem_register.sv
// Scoreboard bench for ex_mem_register: directed vectors push hand-computed expectations, a monitor compares.
// Expectations for the address guard follow EX_MEM_ADDR_GUARD_EN.
module tb_ex_mem_register;

   typedef struct packed {
      logic        valid, branch, mw, mr, rw, m2r, zero;
      logic [31:0] alu;
      logic [31:0] wd;
      logic [4:0]  wr;
      logic [31:0] tgt;
   } in_t;

   typedef struct packed {
      logic        valid, branch, mw, mr, rw, m2r, zero;
      logic [31:0] alu;
      logic [31:0] wd;
      logic [4:0]  wr;
      logic [31:0] tgt;
      logic        fault;
      logic [6:0]  addr;
   } out_t;

`ifdef EX_MEM_ADDR_GUARD_EN
   localparam logic GUARD = 1'b1;
`else
   localparam logic GUARD = 1'b0;
`endif

   localparam in_t IN_A = '{valid:1'b1, rw:1'b1, alu:32'h14, wd:32'h11, wr:5'd3, tgt:32'h100, default:'0};
   localparam in_t IN_B = '{valid:1'b1, mw:1'b1, alu:32'h28, wd:32'hDEAD_BEEF, wr:5'd7, tgt:32'h200, default:'0};
   localparam in_t IN_C = '{valid:1'b1, branch:1'b1, zero:1'b1, tgt:32'h40, default:'0};
   localparam in_t IN_D = '{mw:1'b1, rw:1'b1, alu:32'h8, wd:32'h5, wr:5'd2, default:'0};
   localparam in_t IN_W = '{valid:1'b1, rw:1'b1, alu:32'hFF, wr:5'd31, default:'0};
   localparam in_t IN_E = '{valid:1'b1, mw:1'b1, alu:32'h84, wd:32'h5, default:'0};
   localparam in_t IN_F = '{valid:1'b1, mw:1'b1, alu:32'h4, wd:32'h6, default:'0};
   localparam in_t IN_G = '{valid:1'b1, mr:1'b1, m2r:1'b1, rw:1'b1, alu:32'h1000_0010, wr:5'd9, default:'0};

   localparam out_t ZERO  = '0;
   localparam out_t EXP_A = '{valid:1'b1, rw:1'b1, alu:32'h14, wd:32'h11, wr:5'd3, tgt:32'h100,
                              addr:7'h14, default:'0};
   localparam out_t EXP_B = '{valid:1'b1, mw:1'b1, alu:32'h28, wd:32'hDEAD_BEEF, wr:5'd7, tgt:32'h200,
                              addr:7'h28, default:'0};
   localparam out_t EXP_C = '{valid:1'b1, branch:1'b1, zero:1'b1, tgt:32'h40, default:'0};
   localparam out_t EXP_W = '{valid:1'b1, rw:1'b1, alu:32'hFF, wr:5'd31, addr:7'h7F, default:'0};
   localparam out_t EXP_E = '{valid:1'b1, mw:~GUARD, alu:32'h84, wd:32'h5, fault:GUARD, addr:7'h04, default:'0};
   localparam out_t EXP_F = '{valid:1'b1, mw:1'b1, alu:32'h4, wd:32'h6, addr:7'h04, default:'0};
   localparam out_t EXP_G = '{valid:1'b1, mr:1'b1, m2r:1'b1, rw:1'b1, alu:32'h1000_0010, wr:5'd9,
                              fault:GUARD, addr:7'h10, default:'0};

   logic        clk = 1'b0;
   logic        reset = 1'b1, stall = 1'b0, flush = 1'b0, mem_pc_src = 1'b0;
   in_t         ex = '0;
   logic        mem_valid, mem_branch, mem_mem_write, mem_mem_read, mem_reg_write, mem_mem_to_reg, mem_zero;
   logic [31:0] mem_alu_result, mem_write_data, mem_branch_target;
   logic [6:0]  mem_address;
   logic [4:0]  mem_write_reg;
   logic        mem_addr_fault;

   out_t  exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    errors = 0;

   always #5 clk = ~clk;

   ex_mem_register #(.ADDR_WIDTH(7), .DATA_WIDTH(32), .REG_BITS(5)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .mem_pc_src(mem_pc_src),
      .ex_valid(ex.valid), .ex_branch(ex.branch), .ex_mem_write(ex.mw), .ex_mem_read(ex.mr),
      .ex_reg_write(ex.rw), .ex_mem_to_reg(ex.m2r), .ex_zero(ex.zero),
      .ex_alu_result(ex.alu), .ex_write_data(ex.wd), .ex_write_reg(ex.wr), .ex_branch_target(ex.tgt),
      .mem_valid(mem_valid), .mem_branch(mem_branch), .mem_mem_write(mem_mem_write),
      .mem_mem_read(mem_mem_read), .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
      .mem_zero(mem_zero), .mem_alu_result(mem_alu_result), .mem_address(mem_address),
      .mem_write_data(mem_write_data), .mem_write_reg(mem_write_reg),
      .mem_branch_target(mem_branch_target), .mem_addr_fault(mem_addr_fault)
   );

   // Monitor: the register presents a new output state after every edge.
   initial begin : monitor
      out_t  act, e;
      string nm;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            act = '{valid:mem_valid, branch:mem_branch, mw:mem_mem_write, mr:mem_mem_read,
                    rw:mem_reg_write, m2r:mem_mem_to_reg, zero:mem_zero, alu:mem_alu_result,
                    wd:mem_write_data, wr:mem_write_reg, tgt:mem_branch_target,
                    fault:mem_addr_fault, addr:mem_address};
            checks++;
            if (act !== e) begin
               errors++;
               $display("FAIL %s: got %h expected %h", nm, act, e);
            end
         end
      end
   end

   task automatic step(input string nm, input logic rst, input logic stl, input logic fl,
                       input logic pcs, input in_t ins, input out_t e);
      @(negedge clk);
      reset      = rst;
      stall      = stl;
      flush      = fl;
      mem_pc_src = pcs;
      ex         = ins;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge clk);
   endtask

   function automatic in_t rand_in();
      in_t r;
      r.valid  = 1'b1;
      r.branch = 1'($urandom_range(1));
      r.mw     = 1'b1;
      r.mr     = 1'($urandom_range(1));
      r.rw     = 1'b1;
      r.m2r    = 1'($urandom_range(1));
      r.zero   = 1'($urandom_range(1));
      r.alu    = $urandom();
      r.wd     = $urandom();
      r.wr     = 5'($urandom_range(31));
      r.tgt    = $urandom();
      return r;
   endfunction

   initial begin : stimulus
      step("reset_0", 1'b1, 1'b0, 1'b0, 1'b0, rand_in(), ZERO);
      step("reset_1", 1'b1, 1'b0, 1'b0, 1'b0, rand_in(), ZERO);
      step("load_a", 1'b0, 1'b0, 1'b0, 1'b0, IN_A, EXP_A);
      step("stall_0", 1'b0, 1'b1, 1'b0, 1'b0, IN_B, EXP_A);
      step("stall_1", 1'b0, 1'b1, 1'b0, 1'b0, IN_C, EXP_A);
      step("stall_2", 1'b0, 1'b1, 1'b0, 1'b0, IN_G, EXP_A);
      step("unstall_b", 1'b0, 1'b0, 1'b0, 1'b0, IN_B, EXP_B);
      step("load_branch", 1'b0, 1'b0, 1'b0, 1'b0, IN_C, EXP_C);
      step("pcsrc_beats_stall", 1'b0, 1'b1, 1'b0, 1'b1, IN_B, ZERO);
      step("pcsrc_again", 1'b0, 1'b0, 1'b0, 1'b1, IN_A, ZERO);
      step("reload_a", 1'b0, 1'b0, 1'b0, 1'b0, IN_A, EXP_A);
      step("flush", 1'b0, 1'b0, 1'b1, 1'b0, IN_B, ZERO);
      step("invalid_ex", 1'b0, 1'b0, 1'b0, 1'b0, IN_D, ZERO);
      step("addr_slice_7f", 1'b0, 1'b0, 1'b0, 1'b0, IN_W, EXP_W);
      step("store_84", 1'b0, 1'b0, 1'b0, 1'b0, IN_E, EXP_E);
      step("store_84_stall", 1'b0, 1'b1, 1'b0, 1'b0, IN_F, EXP_E);
      step("store_04", 1'b0, 1'b0, 1'b0, 1'b0, IN_F, EXP_F);
      step("store_84_again", 1'b0, 1'b0, 1'b0, 1'b0, IN_E, EXP_E);
      step("flush_clears_fault", 1'b0, 1'b0, 1'b1, 1'b0, IN_E, ZERO);
      step("load_high_addr", 1'b0, 1'b0, 1'b0, 1'b0, IN_G, EXP_G);
      step("store_b", 1'b0, 1'b0, 1'b0, 1'b0, IN_B, EXP_B);
      step("reset_in_stall", 1'b1, 1'b1, 1'b0, 1'b0, IN_B, ZERO);
      step("reset_in_flush", 1'b1, 1'b0, 1'b1, 1'b1, IN_A, ZERO);
      step("post_reset_load", 1'b0, 1'b0, 1'b0, 1'b0, IN_A, EXP_A);

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
